// File: rtl/vram_arbiter.sv
// Pixel-memory arbiter: VGA scan-out fetch has priority, and game writes
// drain from a small FIFO in every non-fetch cycle.
module vram_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              in_vblank
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fa_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fdat_mem [FIFO_DEPTH];

    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rdy_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              v1_q, v2_q, fd_q, vb_q;

    logic              fetch, push, pop, head_ok, wr_go;
    logic [ADDR_W-1:0] vrow, hcol, faddr, head_a;

    // FB_W = 160 multiply as (row << 7) + (row << 5)
    assign vrow  = ADDR_W'(v_cnt[9:2]);
    assign hcol  = ADDR_W'(h_cnt[9:2]);
    assign faddr = (vrow << 7) + (vrow << 5) + hcol;

    assign fetch   = !rst && valid && (h_cnt[1:0] == 2'b00);
    assign push    = wr_valid && rdy_q;
    assign pop     = !fetch && (cnt_q != '0);
    assign head_a  = fa_mem[rp_q];
    assign head_ok = head_a < FB_SIZE;
    assign wr_go   = pop && head_ok;

    always_comb begin
        wp_d    = push ? wp_q + PW'(1) : wp_q;
        rp_d    = pop  ? rp_q + PW'(1) : rp_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (fetch) begin
            addr_d = faddr;
        end else if (wr_go) begin
            addr_d  = head_a;
            wdata_d = fdat_mem[rp_q];
        end
        hold_d = fd_q ? mem_rdata : hold_q;
    end

    assign mem_en    = fetch || wr_go;
    assign mem_we    = wr_go;
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;
    assign wr_err    = pop && !head_ok;
    assign wr_ready  = rdy_q;
    assign pix_rgb   = v2_q ? hold_q : '0;
    assign in_vblank = vb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            fd_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            rdy_q   <= cnt_d < DEPTH_C;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            v1_q    <= valid;
            v2_q    <= v1_q;
            fd_q    <= fetch;
            vb_q    <= v_cnt >= 10'd480;
        end
    end

    // Entry storage needs no reset; the pointers define what is live
    always_ff @(posedge clk) begin
        if (push) begin
            fa_mem[wp_q]   <= wr_addr;
            fdat_mem[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: queue-based reference model checked every cycle,
// plus directed scan-line, vblank, error, full-FIFO and reset cases.
module tb_vram_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int FBS = 19200;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    h_cnt, v_cnt;
    logic          valid, wr_valid, wr_ready, wr_err;
    logic [AW-1:0] wr_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, pix_rgb;
    logic          mem_en, mem_we, in_vblank;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_rgb(pix_rgb), .in_vblank(in_vblank)
    );

    logic [7:0] ram  [32768];
    logic [7:0] eram [32768];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     n, act, exp, $time);
        end
    endtask

    typedef struct { int a; int d; } ent_t;
    ent_t q[$];
    ent_t m_hd;
    int   m_last_a, m_last_d, m_lastval, m_pl1, m_pl2, m_ea, m_ed;
    bit   m_pv1, m_pv2, m_started, m_vb, m_f, m_pop, m_push, m_rdy;
    bit   m_en, m_we, m_err;

    always begin
        @(posedge clk);
        #4;
        if (rst) begin
            chk("rst_en", mem_en, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_pix", pix_rgb, 0);
            chk("rst_err", wr_err, 0);
            chk("rst_vb", in_vblank, 0);
            chk("rst_ready", wr_ready, 0);
            q.delete();
            m_last_a = 0; m_last_d = 0; m_lastval = 0;
            m_pl1 = 0; m_pl2 = 0; m_pv1 = 0; m_pv2 = 0;
            m_started = 0; m_vb = 0;
        end else begin
            m_rdy  = m_started && q.size() < 4;
            m_f    = valid && h_cnt[1:0] == 2'b00;
            m_push = wr_valid && m_rdy;
            m_pop  = !m_f && q.size() > 0;
            m_en = 0; m_we = 0; m_err = 0;
            m_ea = m_last_a; m_ed = m_last_d;
            if (m_f) begin
                m_en = 1;
                m_ea = int'(v_cnt) / 4 * 160 + int'(h_cnt) / 4;
                m_last_a = m_ea;
                m_lastval = int'(eram[m_ea]);
            end else if (m_pop) begin
                m_hd = q.pop_front();
                if (m_hd.a < FBS) begin
                    m_en = 1; m_we = 1;
                    m_ea = m_hd.a; m_ed = m_hd.d;
                    m_last_a = m_ea; m_last_d = m_ed;
                    eram[m_ea] = 8'(m_ed);
                end else begin
                    m_err = 1;
                end
            end
            chk("ready", wr_ready, m_rdy);
            chk("mem_en", mem_en, m_en);
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_ea);
            chk("mem_wdata", mem_wdata, m_ed);
            chk("wr_err", wr_err, m_err);
            chk("pix", pix_rgb, m_pv2 ? m_pl2 : 0);
            chk("vblank", in_vblank, m_vb);
            if (m_push) q.push_back('{int'(wr_addr), int'(wr_data)});
            m_pv2 = m_pv1; m_pl2 = m_pl1;
            m_pv1 = valid; m_pl1 = m_lastval;
            m_vb = v_cnt >= 10'd480;
            m_started = 1;
        end
    end

    task automatic drv(input bit r, input bit vl, input int h,
                       input int v, input bit wv, input int wa,
                       input int wd);
        @(posedge clk);
        #1;
        rst = r; valid = vl;
        h_cnt = 10'(h); v_cnt = 10'(v);
        wr_valid = wv; wr_addr = AW'(wa); wr_data = DW'(wd);
    endtask

    task automatic idle(input int v);
        drv(0, 0, 0, v, 0, 0, 0);
    endtask

    int writes;
    int wa;

    initial begin
        rst = 0; valid = 0; h_cnt = 0; v_cnt = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        for (int k = 0; k < 32768; k++) begin
            ram[k]  = 8'(k);
            eram[k] = 8'(k);
        end
        #2 rst = 1;
        drv(1, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 8, 1, 5, 5);
        #3;
        chk("L_rst_en", mem_en, 0);
        chk("L_rst_ready", wr_ready, 0);
        idle(0);
        #3 chk("L_ready_first", wr_ready, 0);
        idle(0);
        #3 chk("L_ready_up", wr_ready, 1);

        // scan line v=8: fetches at 320..323, pixels 0x40, 0x41 ...
        for (int h = 0; h < 20; h++) begin
            drv(0, h < 16, h, 8, 0, 0, 0);
            #3;
            case (h)
                0:  chk("L_addr0", mem_addr, 320);
                4:  chk("L_addr4", mem_addr, 321);
                8:  chk("L_addr8", mem_addr, 322);
                12: chk("L_addr12", mem_addr, 323);
                2:  chk("L_pix2", pix_rgb, 8'h40);
                5:  chk("L_pix5", pix_rgb, 8'h40);
                6:  chk("L_pix6", pix_rgb, 8'h41);
                9:  chk("L_pix9", pix_rgb, 8'h41);
                17: chk("L_pix17", pix_rgb, 8'h43);
                18: chk("L_pix18", pix_rgb, 0);
                default: ;
            endcase
        end

        // vblank writes land on consecutive cycles in order
        drv(0, 0, 0, 490, 1, 0, 'hE0);
        drv(0, 0, 1, 490, 1, 19199, 'h1C);
        #3;
        chk("L_vb_we0", mem_we, 1);
        chk("L_vb_a0", mem_addr, 0);
        chk("L_vb_d0", mem_wdata, 8'hE0);
        chk("L_vblank", in_vblank, 1);
        idle(490);
        #3;
        chk("L_vb_a1", mem_addr, 19199);
        chk("L_vb_d1", mem_wdata, 8'h1C);
        idle(490);
        #3 chk("L_vb_idle", mem_en, 0);

        // out-of-range entry between two good ones
        drv(0, 0, 0, 490, 1, 100, 'h11);
        drv(0, 0, 0, 490, 1, 19200, 'h22);
        #3 chk("L_err_a100", mem_addr, 100);
        drv(0, 0, 0, 490, 1, 101, 'h33);
        #3;
        chk("L_err_pulse", wr_err, 1);
        chk("L_err_noen", mem_en, 0);
        idle(490);
        #3;
        chk("L_err_a101", mem_addr, 101);
        chk("L_err_once", wr_err, 0);
        idle(490);
        #3 chk("L_err_drained", mem_en, 0);

        // continuous writer during active video
        writes = 0;
        for (int h = 0; h < 32; h++) begin
            drv(0, 1, h, 20, 1, $urandom_range(0, FBS - 1), $urandom);
            #3;
            writes += int'(mem_we);
            if (h % 4 == 0) chk("L_no_we_fetch", mem_we, 0);
            if (h == 13) begin
                chk("L_full_ready", wr_ready, 0);
                chk("L_full_pop", mem_we, 1);
            end
            if (h == 14) chk("L_refill_ready", wr_ready, 1);
        end
        chk("L_3of4", writes, 24);
        for (int i = 0; i < 8; i++) idle(490);

        // reset mid-line with three entries queued
        for (int h = 0; h < 10; h++)
            drv(0, 1, h, 24, 1, $urandom_range(0, FBS - 1), $urandom);
        drv(1, 1, 10, 24, 1, 7, 7);
        #3;
        chk("L_mrst_en", mem_en, 0);
        chk("L_mrst_pix", pix_rgb, 0);
        drv(1, 0, 11, 24, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 12 + i, 24, 0, 0, 0);
            #3 chk("L_no_stale", mem_en, 0);
        end
        chk("L_mrst_ready", wr_ready, 1);

        // randomized lines mixing active video and blanking
        for (int ln = 0; ln < 60; ln++) begin
            int v;
            v = $urandom_range(0, 524);
            for (int h = 0; h < 48; h++) begin
                if ($urandom_range(0, 15) == 0)
                    wa = $urandom_range(FBS, 32767);
                else
                    wa = $urandom_range(0, FBS - 1);
                drv($urandom_range(0, 499) == 0, h < 40 && v < 480, h, v,
                    $urandom_range(0, 3) != 0, wa, $urandom);
            end
        end
        for (int i = 0; i < 6; i++) idle(500);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read pixel memory between two users.
  - The VGA scan-out fetch path, which has absolute priority.
  - Game-logic pixel writers, which are buffered in a small write FIFO.
- Framebuffer is 160x120 RGB332, with each stored pixel shown as a 4x4 block on the 640x480 screen.
- Sits on the 25 MHz pixel clock. Takes h_cnt/v_cnt/valid from vga_sync and feeds pix_rgb to the colour expansion in the top level.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- ADDR_W, 15, memory address width (must cover FB_W*FB_H = 19200).
- DATA_W, 8, pixel width (RGB332).
- FIFO_DEPTH, 4, write FIFO entries (power of two).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  reset, asynchronous, active-high; one clock domain only.
- h_cnt  in  10  horizontal counter from vga_sync.
- v_cnt  in  10  vertical counter from vga_sync.
- valid  in  1  active-video flag from vga_sync.
- wr_valid  in  1  writer request.
- wr_ready  out  1  FIFO can accept an entry.
- wr_addr  in  ADDR_W  linear pixel address (y*FB_W + x).
- wr_data  in  DATA_W  pixel value.
- wr_err  out  1  one-cycle pulse when an out-of-range entry is discarded.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; only meaningful when mem_en=1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid 1 cycle after a read.
- pix_rgb  out  DATA_W  pixel to display, 2-cycle latency from h_cnt/v_cnt/valid.
- in_vblank  out  1  registered, 1 when v_cnt >= 480.

Behaviour:
- Reset values, all asynchronous on rst=1:
  - Outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_rgb=0, wr_err=0, in_vblank=0, wr_ready=0.
  - FIFO pointers and count cleared.
  - wr_ready rises on the first clock after rst deasserts.
- Reset mid-frame drops all FIFO contents. Scan-out resumes at the next fetch slot.
- Fetch slot is any cycle with valid=1 and h_cnt[1:0]=00.
  - Drive mem_en=1, mem_we=0, mem_addr = (v_cnt>>2)*FB_W + (h_cnt>>2).
  - Compute the multiply as shift-add: (v>>2)<<7 + (v>>2)<<5.
- Pixel pipeline:
  - Stage 1 registers valid as v1 and marks fetch_d when the cycle was a fetch slot.
  - Stage 2: if fetch_d, latch mem_rdata into the pixel hold register.
  - pix_rgb = hold register when the 2-cycle-delayed valid (v2) is 1, else 0.
  - Each fetched value is therefore shown for exactly 4 cycles.
  - The top level delays hsync/vsync by 2 cycles to match.
- Write FIFO:
  - Push when wr_valid && wr_ready. wr_ready = (count < FIFO_DEPTH), computed from the registered count.
  - When full, a same-cycle pop does not allow a push that cycle.
- Write drain:
  - In any non-fetch cycle with the FIFO non-empty, pop the head.
  - If head addr < FB_W*FB_H: mem_en=1, mem_we=1, drive addr/data.
  - Otherwise: no memory access, and wr_err pulses for 1 cycle.
  - Fetch and write never share a cycle. On a fetch slot the write waits; drain order is strictly FIFO.
- Throughput: during active video the writer gets 3 of every 4 cycles; in blanking it gets every cycle.
- Idle cycles (no fetch, FIFO empty): mem_en=0. mem_addr/mem_wdata hold their last values.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- in_vblank is registered from v_cnt, with 1-cycle latency.

Test Plan:
- Reset is asserted mid-line with 3 FIFO entries -> immediately mem_en=0 and pix_rgb=0; after release wr_ready=1 and count=0, and no stale writes appear.
- Memory preloaded with addr k holding k[7:0]; scan line v_cnt=8, h_cnt 0..15 -> reads at addr 320,321,322,323 on h_cnt 0,4,8,12; pix_rgb = 0x40 for h_cnt 2..5, 0x41 for h_cnt 6..9; pix_rgb=0 two cycles after valid falls.
- Writer holds wr_valid=1 continuously during active video with the memory stubbed -> FIFO fills to 4 and wr_ready=0; exactly 3 writes per 4 cycles; no mem_we=1 on any h_cnt[1:0]=00 valid cycle.
- Writes pushed to addr 0 (0xE0) then addr 19199 (0x1C) during vblank -> mem writes on consecutive cycles in that order; in_vblank=1.
- Push to addr 19200 between two valid writes -> wr_err pulses once; only the two valid writes reach memory, in order.
- Full FIFO with a push attempt on the same cycle as a pop -> push refused; wr_ready=1 on the next cycle.
